test_i16435: RTL and testbench
==============================

TEST_I16435 -- requirements
Module: test_i16435

Interface
REQ-001 Parameters: none; all widths are fixed.
REQ-002 CK  input  1  clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset; clears all state immediately, independent of CK.
REQ-004 N0  input  1  data bit 0, the MSB of the 5-bit stimulus word N0..N4.
REQ-005 N1  input  1  data bit 1.
REQ-006 N2  input  1  data bit 2.
REQ-007 N3  input  1  data bit 3.
REQ-008 N4  input  1  data bit 4, the LSB of the word; word 5'b00001 means N4=1.
REQ-009 out  output  1  registered single-bit result.
REQ-010 Port order SHALL be N0, N1, N2, N3, N4, CK, reset, out, so positional instantiation works.

Function
REQ-011 Stage-1 registers SHALL capture on each CK rise: a <= N0 XOR N1; b <= N2 AND N3; c <= N4.
REQ-012 Stage-2 registers SHALL update on each CK rise from the pre-edge stage-1 values: d <= a OR b; e <= NOT(b AND c).
REQ-013 Output register SHALL update on each CK rise: out <= d XOR e XOR t, using pre-edge d, e and t.
REQ-014 Latency: inputs sampled at edge k SHALL appear on out after edge k+2; out has no combinational path from any input.
REQ-015 A 3-bit counter cnt SHALL track consecutive rising edges at which N0..N4 are sampled as 5'b11111.
REQ-016 Counter update when cnt<7: cnt <= cnt+1 if the sampled word is 11111, otherwise cnt <= 0.
REQ-017 Once cnt=7, cnt SHALL hold at 7 regardless of the inputs; it never wraps, and only reset clears it.
REQ-018 Trigger t SHALL equal (cnt==7); after the 7th consecutive 11111 edge, out is inverted from the next edge on, persistently.
REQ-019 All registers SHALL be single-bit except cnt; there is no handshake, and every edge is a valid sample.

Reset
REQ-020 While reset=1, the following SHALL be held at 0: a, b, c, d, e, cnt and out.
REQ-021 On the first CK rise after reset deasserts, out SHALL be 0: computed from reset values, d=0, e=0, t=0.
REQ-022 Reset asserted mid-operation SHALL clear out and cnt at once, including a saturated trigger, without waiting for CK.
REQ-023 Reset deassertion SHALL be safe with inputs changing; the first capture is the first rise with reset=0.

Verification
REQ-024 Reset check: assert reset with any N -> out=0 immediately, and stays 0 through reset; the first edge after release still gives out=0.
REQ-025 Word check: hold N=00000 after reset -> out=0 after edge 1 and out=1 from edge 2 onward (d=0, e=1).
REQ-026 Pattern set, each held for 3 or more edges:
- N=10000 -> out=0 (d=1, e=1)
- N=11000 -> out=1
- N=00111 -> out=1 (d=1, e=0)
- N=00110 -> out=0
- N=00001 -> out=1
REQ-027 Trigger, positive case: hold N=11111 from edge 1 -> out=1 at edges 3..7; out=0 from edge 8 on (t=1).
REQ-028 Trigger persistence: after saturation switch to N=00000 -> out=0 (inverted) persistently; assert reset -> out=0, then N=00000 -> out=1 again from edge 2 after release.
REQ-029 Trigger, negative case: apply 11111 for 6 edges, then 1 edge of 00000, then 11111 for 6 edges -> cnt never reaches 7 and out is never inverted; also sweep all 32 words, 1 per half-period, and compare against a reference model.

Source files
------------

// File: rtl/test_i16435.sv
// -----------------------------------------------------------------------------
// test_i16435
//
// Purpose:
//   Two-stage registered logic pipeline over a 5-bit stimulus word N0..N4
//   (N0 is the MSB). A sticky trigger inverts the output once the word 5'b11111
//   has been sampled on seven consecutive rising edges.
//
//   Stage 1 : a = N0 ^ N1, b = N2 & N3, c = N4
//   Stage 2 : d = a | b,   e = ~(b & c)
//   Output  : out = d ^ e ^ t, where t = (cnt == 7)
//
//   Inputs sampled at edge k reach out after edge k+2. The output is taken
//   directly from a flop, so there is no combinational path from any input.
//
// Ports:
//   N0..N4  in   1   stimulus word bits, N0 = MSB, N4 = LSB
//   CK      in   1   clock, rising-edge active
//   reset   in   1   asynchronous active-high reset, clears all state
//   out     out  1   registered result
// -----------------------------------------------------------------------------
module test_i16435 (
  input  logic N0,
  input  logic N1,
  input  logic N2,
  input  logic N3,
  input  logic N4,
  input  logic CK,
  input  logic reset,
  output logic out
);

  localparam logic [4:0] ALL_ONES = 5'b11111;
  localparam logic [2:0] CNT_MAX  = 3'd7;

  logic [4:0] word_s;
  logic       t_s;

  logic       a_q,   a_d;
  logic       b_q,   b_d;
  logic       c_q,   c_d;
  logic       d_q,   d_d;
  logic       e_q,   e_d;
  logic       out_q, out_d;
  logic [2:0] cnt_q, cnt_d;

  // Three-input parity used for the output stage.
  function automatic logic xor3(input logic x, input logic y, input logic z);
    return x ^ y ^ z;
  endfunction

  assign word_s = {N0, N1, N2, N3, N4};

  // The trigger is the saturated state of the run counter; it stays set until reset.
  assign t_s = (cnt_q == CNT_MAX);

  // Next-state logic for both pipeline stages, the output flop and the run counter.
  always_comb begin
    a_d   = 1'b0;
    b_d   = 1'b0;
    c_d   = 1'b0;
    d_d   = 1'b0;
    e_d   = 1'b0;
    out_d = 1'b0;
    cnt_d = 3'd0;

    a_d   = N0 ^ N1;
    b_d   = N2 & N3;
    c_d   = N4;

    d_d   = a_q | b_q;
    e_d   = ~(b_q & c_q);

    out_d = xor3(d_q, e_q, t_s);

    // Saturate at 7 rather than wrap; only reset leaves the saturated state.
    if (cnt_q == CNT_MAX) begin
      cnt_d = cnt_q;
    end else if (word_s == ALL_ONES) begin
      cnt_d = cnt_q + 3'd1;
    end else begin
      cnt_d = 3'd0;
    end
  end

  // State registers with asynchronous active-high clear.
  always_ff @(posedge CK or posedge reset) begin
    if (reset) begin
      a_q   <= 1'b0;
      b_q   <= 1'b0;
      c_q   <= 1'b0;
      d_q   <= 1'b0;
      e_q   <= 1'b0;
      out_q <= 1'b0;
      cnt_q <= 3'd0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      c_q   <= c_d;
      d_q   <= d_d;
      e_q   <= e_d;
      out_q <= out_d;
      cnt_q <= cnt_d;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_test_i16435.sv
// -----------------------------------------------------------------------------
// tb_test_i16435
//
// Self-checking bench for test_i16435. Directed scenarios use expected values
// worked out by hand from the block's rules; randomized and sweep scenarios use
// a history-based reference model: the list of words sampled since the last
// reset determines the output directly (word two edges back, plus whether any
// run of seven consecutive 11111 words exists in the history).
// -----------------------------------------------------------------------------
module tb_test_i16435;

  logic N0, N1, N2, N3, N4;
  logic CK;
  logic reset;
  logic out;

  int checks = 0;
  int errors = 0;

  // Words sampled at each rising edge since the last reset release.
  logic [4:0] hist[$];

  test_i16435 dut (
    .N0   (N0),
    .N1   (N1),
    .N2   (N2),
    .N3   (N3),
    .N4   (N4),
    .CK   (CK),
    .reset(reset),
    .out  (out)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  task automatic drive(input logic [4:0] w);
    {N0, N1, N2, N3, N4} = w;
  endtask

  // Present a word, take one rising edge, record it, settle 1ns past the edge.
  task automatic edge_in(input logic [4:0] w);
    drive(w);
    @(posedge CK);
    hist.push_back(w);
    #1;
  endtask

  // Assert reset mid-cycle, hold for two edges, release away from an edge
  // while the inputs also change.
  task automatic apply_reset();
    #2;
    reset = 1'b1;
    @(posedge CK);
    @(posedge CK);
    #3;
    drive(5'($urandom_range(0, 31)));
    reset = 1'b0;
    hist.delete();
  endtask

  // Expected value of out after the most recent recorded edge.
  function automatic logic model_out();
    int   k;
    int   j;
    int   run;
    logic d;
    logic e;
    logic t;
    logic [4:0] w;
    k = hist.size();
    if (k == 0) return 1'b0;
    j = k - 1;                       // out after edge k uses state after edge j
    if (j <= 1) begin
      d = 1'b0;
    end else begin
      w = hist[j-2];
      d = (w[4] ^ w[3]) | (w[2] & w[1]);
    end
    if (j == 0) begin
      e = 1'b0;
    end else if (j == 1) begin
      e = 1'b1;                      // computed from the cleared stage-1 values
    end else begin
      w = hist[j-2];
      e = ~(w[2] & w[1] & w[0]);
    end
    t   = 1'b0;
    run = 0;
    for (int i = 0; i < j; i++) begin
      if (hist[i] == 5'h1F) run = run + 1;
      else run = 0;
      if (run >= 7) t = 1'b1;
    end
    return d ^ e ^ t;
  endfunction

  task automatic test_reset();
    logic exp_v;
    reset = 1'b1;
    drive(5'($urandom_range(0, 31)));
    #1;
    checks++;
    if (out !== 1'b0) begin
      errors++;
      $display("FAIL reset_immediate: out=%b expected=0", out);
    end
    for (int i = 0; i < 3; i++) begin
      drive(5'($urandom_range(0, 31)));
      @(posedge CK);
      #1;
      checks++;
      if (out !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold edge%0d: out=%b expected=0", i, out);
      end
    end
    #3;
    drive(5'($urandom_range(0, 31)));
    reset = 1'b0;
    hist.delete();
    edge_in(5'($urandom_range(0, 31)));
    exp_v = model_out();
    checks++;
    if (out !== 1'b0 || exp_v !== 1'b0) begin
      errors++;
      $display("FAIL reset_first_edge: out=%b model=%b expected=0", out, exp_v);
    end
  endtask

  task automatic test_word_zero();
    apply_reset();
    for (int k = 1; k <= 5; k++) begin
      edge_in(5'b00000);
      checks++;
      if (out !== ((k == 1) ? 1'b0 : 1'b1)) begin
        errors++;
        $display("FAIL word_zero edge%0d: out=%b expected=%b", k, out, (k == 1) ? 1'b0 : 1'b1);
      end
    end
  endtask

  task automatic test_patterns();
    logic [4:0] pat [5];
    logic       res [5];
    pat = '{5'b10000, 5'b11000, 5'b00111, 5'b00110, 5'b00001};
    res = '{1'b0,     1'b1,     1'b1,     1'b1 ^ 1'b1, 1'b1};
    apply_reset();
    for (int p = 0; p < 5; p++) begin
      for (int k = 1; k <= 4; k++) begin
        edge_in(pat[p]);
        if (k >= 3) begin
          checks++;
          if (out !== res[p] || model_out() !== res[p]) begin
            errors++;
            $display("FAIL pattern %b edge%0d: out=%b model=%b expected=%b",
                     pat[p], k, out, model_out(), res[p]);
          end
        end
      end
    end
  endtask

  task automatic test_trigger_pos();
    logic exp_v;
    apply_reset();
    for (int k = 1; k <= 10; k++) begin
      edge_in(5'b11111);
      if (k >= 3) begin
        exp_v = (k <= 7) ? 1'b1 : 1'b0;
        checks++;
        if (out !== exp_v || model_out() !== exp_v) begin
          errors++;
          $display("FAIL trigger_pos edge%0d: out=%b model=%b expected=%b",
                   k, out, model_out(), exp_v);
        end
      end
    end
  endtask

  // Continues from a saturated trigger left by test_trigger_pos.
  task automatic test_trigger_persist();
    for (int k = 1; k <= 6; k++) begin
      edge_in(5'b00000);
      checks++;
      if (out !== 1'b0) begin
        errors++;
        $display("FAIL persist_inverted edge%0d: out=%b expected=0", k, out);
      end
    end
    // Drive out high (d=1, e=1, t=1) so the asynchronous clear is visible.
    for (int k = 1; k <= 3; k++) edge_in(5'b10000);
    checks++;
    if (out !== 1'b1) begin
      errors++;
      $display("FAIL persist_pre_reset: out=%b expected=1", out);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (out !== 1'b0) begin
      errors++;
      $display("FAIL persist_async_clear: out=%b expected=0", out);
    end
    @(posedge CK);
    #3;
    reset = 1'b0;
    hist.delete();
    for (int k = 1; k <= 5; k++) begin
      edge_in(5'b00000);
      checks++;
      if (out !== ((k == 1) ? 1'b0 : 1'b1)) begin
        errors++;
        $display("FAIL persist_after_reset edge%0d: out=%b expected=%b",
                 k, out, (k == 1) ? 1'b0 : 1'b1);
      end
    end
  endtask

  task automatic test_trigger_neg();
    apply_reset();
    for (int k = 1; k <= 15; k++) begin
      edge_in((k == 7 || k >= 14) ? 5'b00000 : 5'b11111);
      if (k >= 2) begin
        checks++;
        if (out !== 1'b1 || model_out() !== 1'b1) begin
          errors++;
          $display("FAIL trigger_neg edge%0d: out=%b model=%b expected=1",
                   k, out, model_out());
        end
      end
    end
  endtask

  // Every word once, with a different word in the other half of each period.
  task automatic test_sweep();
    logic exp_v;
    apply_reset();
    for (int w = 0; w < 32; w++) begin
      drive(5'(31 - w));
      @(negedge CK);
      drive(5'(w));
      @(posedge CK);
      hist.push_back(5'(w));
      #1;
      exp_v = model_out();
      checks++;
      if (out !== exp_v) begin
        errors++;
        $display("FAIL sweep word%0d: out=%b expected=%b", w, out, exp_v);
      end
    end
  endtask

  task automatic test_random();
    logic       exp_v;
    logic [4:0] w;
    apply_reset();
    for (int n = 0; n < 400; n++) begin
      if (n == 200) apply_reset();
      // Bias toward 11111 so runs of various lengths, including saturation, occur.
      w = ($urandom_range(0, 99) < 80) ? 5'b11111 : 5'($urandom_range(0, 31));
      edge_in(w);
      exp_v = model_out();
      checks++;
      if (out !== exp_v) begin
        errors++;
        $display("FAIL random cycle%0d: out=%b expected=%b", n, out, exp_v);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    drive(5'b00000);
    test_reset();
    test_word_zero();
    test_patterns();
    test_trigger_pos();
    test_trigger_persist();
    test_trigger_neg();
    test_sweep();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
